uart_tx_sequencer: RTL and testbench

- Sequences one shared flexible counter, used as the bit-period timebase, to serialize bytes as 8N1 UART frames (start, DATA_BITS data bits LSB first, stop).
- Owns the counter's clear, enable and maxCount controls and consumes its strobe.
- Accepts bytes over a valid/ready handshake and holds the programmable baud divisor.
- Sits between the keystroke/byte source and the serial output pin.

---
 rtl/uart_tx_sequencer.sv | 114 +++++++++++
 tb/tb_uart_tx_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// 8N1 UART transmit sequencer driving an external flexible counter as the bit-period timebase.
// Owns the counter's clear/enable/maxCount and advances one bit per counter strobe.
module uart_tx_sequencer #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned COUNTWIDTH      = 16,
  parameter int unsigned DEFAULT_DIVISOR = 868
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  div_load,
  input  logic [COUNTWIDTH-1:0] div_value,
  input  logic [DATA_BITS-1:0]  tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  output logic [COUNTWIDTH-1:0] cnt_max,
  input  logic                  cnt_strobe
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic [COUNTWIDTH-1:0] MinDiv  = COUNTWIDTH'(2);
  localparam logic [COUNTWIDTH-1:0] DefDiv  = COUNTWIDTH'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [COUNTWIDTH-1:0] div_q, div_d;
  logic                  tx_out_q, tx_out_d;
  logic                  frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    div_d        = div_q;
    tx_out_d     = tx_out_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_out_d = 1'b1;
        // Divisor is only writable between frames, so cnt_max is stable for a whole frame.
        if (div_load) begin
          div_d = (div_value < MinDiv) ? MinDiv : div_value;
        end
        if (tx_valid) begin
          shift_d  = tx_data;
          state_d  = StStart;
          tx_out_d = 1'b0;
        end
      end
      StStart: begin
        if (cnt_strobe) begin
          state_d   = StData;
          tx_out_d  = shift_q[0];
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (cnt_strobe) begin
          if (bit_idx_q == LastIdx) begin
            state_d  = StStop;
            tx_out_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
            tx_out_d  = shift_d[0];
          end
        end
      end
      StStop: begin
        if (cnt_strobe) begin
          state_d      = StIdle;
          tx_out_d     = 1'b1;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      div_q        <= DefDiv;
      tx_out_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      div_q        <= div_d;
      tx_out_q     <= tx_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_ready   = (state_q == StIdle);
  assign busy       = ~tx_ready;
  assign cnt_clear  = (state_q == StIdle);
  assign cnt_enable = ~cnt_clear;
  assign cnt_max    = div_q;
  assign tx_out     = tx_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench: each accepted byte pushes its expected per-cycle line waveform,
// and a negedge monitor pops and checks every observable output cycle by cycle.
module tb_uart_tx_sequencer;

  localparam int unsigned DataBits   = 8;
  localparam int unsigned CountWidth = 16;
  localparam int unsigned DefDiv     = 868;
  localparam int unsigned Period     = 4;

  typedef struct packed {
    logic line;
    logic last;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  RST = 1'b1;
  logic                  div_load = 1'b0;
  logic [CountWidth-1:0] div_value = '0;
  logic [DataBits-1:0]   tx_data = '0;
  logic                  tx_valid = 1'b0;
  logic                  tx_ready, tx_out, busy, frame_done;
  logic                  cnt_clear, cnt_enable, cnt_strobe;
  logic [CountWidth-1:0] cnt_max;
  logic                  stray = 1'b0;
  logic [1:0]            cnt_q;

  int unsigned           vectors = 0;
  int unsigned           miscompares = 0;
  ent_t                  exp_q[$];
  ent_t                  mon_e;
  logic                  mon_en = 1'b0;
  logic                  exp_idle = 1'b1;
  logic                  done_due = 1'b0;
  logic                  mon_line, mon_last;
  logic [CountWidth-1:0] exp_div = CountWidth'(DefDiv);

  always #5 clk = ~clk;

  uart_tx_sequencer #(
    .DATA_BITS      (DataBits),
    .COUNTWIDTH     (CountWidth),
    .DEFAULT_DIVISOR(DefDiv)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .div_load  (div_load),
    .div_value (div_value),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done),
    .cnt_clear (cnt_clear),
    .cnt_enable(cnt_enable),
    .cnt_max   (cnt_max),
    .cnt_strobe(cnt_strobe)
  );

  // Counter model: fixed 4-cycle period while enabled, independent of cnt_max.
  always_ff @(posedge clk) begin
    if (RST || cnt_clear) cnt_q <= 2'd0;
    else if (cnt_enable)  cnt_q <= cnt_q + 2'd1;
  end
  assign cnt_strobe = (cnt_enable && (cnt_q == 2'd3)) || stray;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [DataBits-1:0] b);
    ent_t e;
    e.last = 1'b0;
    e.line = 1'b0;
    for (int i = 0; i < int'(Period); i++) exp_q.push_back(e);
    for (int k = 0; k < int'(DataBits); k++) begin
      e.line = b[k];
      for (int i = 0; i < int'(Period); i++) exp_q.push_back(e);
    end
    e.line = 1'b1;
    for (int i = 0; i < int'(Period); i++) begin
      e.last = (i == int'(Period) - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("frame_done", 32'(frame_done), 32'(done_due));
      done_due = 1'b0;
      exp_idle = (exp_q.size() == 0);
      mon_line = 1'b1;
      mon_last = 1'b0;
      if (!exp_idle) begin
        mon_e    = exp_q.pop_front();
        mon_line = mon_e.line;
        mon_last = mon_e.last;
      end
      check_val("tx_out", 32'(tx_out), 32'(mon_line));
      check_val("tx_ready", 32'(tx_ready), 32'(exp_idle));
      check_val("busy", 32'(busy), 32'(!exp_idle));
      check_val("cnt_clear", 32'(cnt_clear), 32'(exp_idle));
      check_val("cnt_enable", 32'(cnt_enable), 32'(!exp_idle));
      check_val("cnt_max", 32'(cnt_max), 32'(exp_div));
      if (mon_last) done_due = 1'b1;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DataBits-1:0] b, input bit hold);
    bit done = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk);
      if (exp_idle) begin
        push_frame(b);
        done = 1'b1;
      end
    end
    check_val("accept", 32'(done), 32'd1);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic load_div(input logic [CountWidth-1:0] v);
    div_load  = 1'b1;
    div_value = v;
    @(posedge clk);
    if (exp_idle) exp_div = (v < 2) ? CountWidth'(2) : v;
    #1;
    div_load = 1'b0;
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int n = 0; n < 400 && !exp_idle; n++) @(posedge clk);
    check_val("idle_reached", 32'(exp_idle), 32'd1);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b0;
    @(negedge clk);
    check_val("rst_tx_out", 32'(tx_out), 32'd1);
    check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_cnt_clear", 32'(cnt_clear), 32'd1);
    check_val("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check_val("rst_cnt_max", 32'(cnt_max), 32'(DefDiv));
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    load_div(16'd4);
    cycles(2);
    // Stray strobe while idle must not start anything.
    stray = 1'b1;
    cycles(1);
    stray = 1'b0;
    cycles(3);

    send(8'hA5, 1'b0);
    cycles(10);
    load_div(16'd10);
    wait_idle();
    cycles(3);

    // Back-to-back with tx_valid held; second byte taken on the frame_done cycle.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();
    cycles(2);

    load_div(16'd0);
    cycles(3);

    // Reset in the middle of data bit 3.
    send(8'h3C, 1'b0);
    cycles(17);
    RST = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_div = CountWidth'(DefDiv);
    #1;
    RST = 1'b0;
    cycles(3);

    load_div(16'd4);
    send(8'h3C, 1'b0);
    wait_idle();
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
